// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: buffers commands, drives them onto a combinational compute unit, returns responses in order
module alu_cmd_issuer #(
  parameter int DEPTH  = 4,
  parameter int SETTLE = 1,
  parameter int TAG_W  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_mode,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [2:0]       alu_mode,
  output logic [7:0]       alu_val1,
  output logic [7:0]       alu_val2,
  input  logic [7:0]       alu_res,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_res,
  output logic [2:0]       rsp_mode,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_dz,
  output logic             busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(SETTLE + 1);
  localparam int EW = 3 + 8 + 8 + TAG_W;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [EW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [2:0]       sh_mode, h_mode;
  logic [TAG_W-1:0] sh_tag, h_tag;
  logic [7:0]       h_a, h_b;
  logic             sh_dz, push, pop;

  assign cmd_ready = count != (AW+1)'(DEPTH);
  assign push = cmd_valid && cmd_ready;
  // RESP always has rsp_valid set, so a pop there is exactly the response handshake
  assign pop = count != '0 && (state == IDLE || (state == RESP && rsp_ready));
  assign {h_mode, h_a, h_b, h_tag} = mem[rd_ptr];
  assign busy = count != '0 || state != IDLE;

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {cmd_mode, cmd_a, cmd_b, cmd_tag};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      state     <= IDLE;
      cnt       <= '0;
      alu_mode  <= '0;
      alu_val1  <= '0;
      alu_val2  <= '0;
      sh_mode   <= '0;
      sh_tag    <= '0;
      sh_dz     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_res   <= '0;
      rsp_mode  <= '0;
      rsp_tag   <= '0;
      rsp_dz    <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (pop) begin
        alu_mode <= h_mode;
        alu_val1 <= h_a;
        alu_val2 <= h_b;
        sh_mode  <= h_mode;
        sh_tag   <= h_tag;
        sh_dz    <= h_mode == 3'b011 && h_b == 8'd0;
        cnt      <= CW'(SETTLE);
        state    <= WAIT;
      end
      if (state == WAIT) begin
        cnt <= cnt - 1'b1;
        if (cnt == CW'(1)) begin
          rsp_res   <= alu_res;
          rsp_mode  <= sh_mode;
          rsp_tag   <= sh_tag;
          rsp_dz    <= sh_dz;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
      end
      if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
        if (!pop) state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb_alu_cmd_issuer: vector table plus scoreboard bench for alu_cmd_issuer (SETTLE=1 and SETTLE=3 instances)
module tb_alu_cmd_issuer;
  logic       clk = 0, rst_n = 0, rst2_n = 0;
  logic       cmd_valid = 0, rsp_ready = 1;
  logic [2:0] cmd_mode = 0;
  logic [7:0] cmd_a = 0, cmd_b = 0;
  logic [1:0] cmd_tag = 0;
  logic       cmd_ready, rsp_valid, rsp_dz, busy;
  logic [2:0] alu_mode, rsp_mode;
  logic [7:0] alu_val1, alu_val2, alu_res, rsp_res;
  logic [1:0] rsp_tag;
  logic       cmd_ready2, rsp_valid2, rsp_dz2, busy2;
  logic [2:0] alu_mode2, rsp_mode2;
  logic [7:0] alu_val1_2, alu_val2_2, rsp_res2;
  logic [7:0] res2 = 0;
  logic [1:0] rsp_tag2;

  always #5 clk = ~clk;

  alu_cmd_issuer #(.DEPTH(4), .SETTLE(1), .TAG_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mode(cmd_mode), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
    .alu_mode(alu_mode), .alu_val1(alu_val1), .alu_val2(alu_val2), .alu_res(alu_res),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_res(rsp_res), .rsp_mode(rsp_mode),
    .rsp_tag(rsp_tag), .rsp_dz(rsp_dz), .busy(busy));

  alu_cmd_issuer #(.DEPTH(4), .SETTLE(3), .TAG_W(2)) dut3 (
    .clk(clk), .rst_n(rst2_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready2),
    .cmd_mode(cmd_mode), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
    .alu_mode(alu_mode2), .alu_val1(alu_val1_2), .alu_val2(alu_val2_2), .alu_res(res2),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready), .rsp_res(rsp_res2), .rsp_mode(rsp_mode2),
    .rsp_tag(rsp_tag2), .rsp_dz(rsp_dz2), .busy(busy2));

  function automatic logic [7:0] model(logic [2:0] m, logic [7:0] a, logic [7:0] b);
    case (m)
      3'b001:  return a + b;
      3'b011:  return b == 8'd0 ? a : a * b;
      3'b100:  return b;
      3'b101:  return a ^ b;
      default: return a - b;
    endcase
  endfunction

  assign alu_res = model(alu_mode, alu_val1, alu_val2);

  typedef struct packed {logic [7:0] res; logic [2:0] mode; logic [1:0] tag; logic dz;} rsp_t;
  typedef struct {logic [2:0] mode; logic [7:0] a, b; logic [1:0] tag; logic [7:0] res; logic dz;} vec_t;

  rsp_t sb[$];
  rsp_t e_mon;
  vec_t vecs[4];
  int passed = 0, total = 0, rsp_seen = 0;

  task automatic check(string name, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic [2:0] m, logic [7:0] a, logic [7:0] b, logic [1:0] t);
    cmd_mode = m;
    cmd_a = a;
    cmd_b = b;
    cmd_tag = t;
    cmd_valid = 1;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 100 && (busy || sb.size() != 0); k++) tick();
    check("drain_timeout", busy, 0);
    check("drain_sb_empty", sb.size(), 0);
  endtask

  // Scoreboard: inputs only change 1 time unit after posedge, so negedge sees the next edge's handshakes
  always @(negedge clk) begin
    if (!rst_n) sb.delete();
    else begin
      if (rsp_valid && rsp_ready) begin
        rsp_seen++;
        if (sb.size() == 0) check("spurious_rsp", 1, 0);
        else begin
          e_mon = sb.pop_front();
          check("sb_res", rsp_res, e_mon.res);
          check("sb_mode", rsp_mode, e_mon.mode);
          check("sb_tag", rsp_tag, e_mon.tag);
          check("sb_dz", rsp_dz, e_mon.dz);
        end
      end
      if (cmd_valid && cmd_ready)
        sb.push_back(rsp_t'{model(cmd_mode, cmd_a, cmd_b), cmd_mode, cmd_tag, cmd_mode == 3'b011 && cmd_b == 8'd0});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    logic [7:0] held_res;
    logic [1:0] held_tag;
    vecs[0] = '{3'b001, 8'd10, 8'd3, 2'd1, 8'd13, 1'b0};
    vecs[1] = '{3'b011, 8'd200, 8'd0, 2'd2, 8'd200, 1'b1};
    vecs[2] = '{3'b011, 8'd3, 8'd5, 2'd3, 8'd15, 1'b0};
    vecs[3] = '{3'b101, 8'hAA, 8'h0F, 2'd0, 8'hA5, 1'b0};
    tick();
    tick();
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_alu_mode", alu_mode, 0);
    check("rst_alu_val1", alu_val1, 0);
    check("rst_rsp_res", rsp_res, 0);
    rst_n = 1;
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].tag);
      tick();
      cmd_valid = 0;
      check("lat_busy", busy, 1);
      check("lat_e0_valid", rsp_valid, 0);
      tick();
      check("lat_alu_val1", alu_val1, vecs[i].a);
      check("lat_alu_val2", alu_val2, vecs[i].b);
      check("lat_e1_valid", rsp_valid, 0);
      tick();
      check("vec_valid", rsp_valid, 1);
      check("vec_res", rsp_res, vecs[i].res);
      check("vec_tag", rsp_tag, vecs[i].tag);
      check("vec_dz", rsp_dz, vecs[i].dz);
      tick();
      check("vec_done_valid", rsp_valid, 0);
      check("vec_done_busy", busy, 0);
    end
    // Backpressure: one command parks in RESP, four fill the FIFO, the sixth is refused
    base = rsp_seen;
    rsp_ready = 0;
    for (int i = 0; i < 5; i++) begin
      drive(3'b101, 8'(i), 8'd1, 2'(i));
      check("bp_ready", cmd_ready, 1);
      tick();
    end
    drive(3'b101, 8'd5, 8'd1, 2'd1);
    check("full_ready", cmd_ready, 0);
    tick();
    tick();
    check("stall_valid", rsp_valid, 1);
    check("stall_tag", rsp_tag, 0);
    check("stall_res", rsp_res, 1);
    held_res = rsp_res;
    held_tag = rsp_tag;
    tick();
    tick();
    check("stable_res", rsp_res, held_res);
    check("stable_tag", rsp_tag, held_tag);
    check("stable_valid", rsp_valid, 1);
    rsp_ready = 1;
    check("full_pop_ready", cmd_ready, 0);
    tick();
    rsp_ready = 0;
    check("after_pop_ready", cmd_ready, 1);
    check("after_pop_valid", rsp_valid, 0);
    tick();
    cmd_valid = 0;
    check("refull_ready", cmd_ready, 0);
    rsp_ready = 1;
    wait_drain();
    check("bp_rsp_count", rsp_seen - base, 6);
    // Reset while one command is in WAIT and three are queued
    rsp_ready = 0;
    for (int i = 0; i < 5; i++) begin
      drive(3'b001, 8'(i), 8'(i), 2'(i));
      tick();
    end
    cmd_valid = 0;
    tick();
    check("pre_rst_valid", rsp_valid, 1);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    check("pre_rst_busy", busy, 1);
    check("pre_rst_wait", rsp_valid, 0);
    rst_n = 0;
    #1;
    check("mid_rst_valid", rsp_valid, 0);
    check("mid_rst_mode", alu_mode, 0);
    check("mid_rst_val1", alu_val1, 0);
    check("mid_rst_val2", alu_val2, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", cmd_ready, 1);
    tick();
    rst_n = 1;
    rsp_ready = 1;
    base = rsp_seen;
    for (int i = 0; i < 6; i++) tick();
    check("no_stale", rsp_seen - base, 0);
    drive(3'b001, 8'd20, 8'd22, 2'd3);
    tick();
    cmd_valid = 0;
    wait_drain();
    check("post_rst_count", rsp_seen - base, 1);
    // SETTLE=3 instance: only alu_res at the fourth edge after acceptance is captured
    rst2_n = 1;
    tick();
    drive(3'b100, 8'd7, 8'd9, 2'd2);
    tick();
    cmd_valid = 0;
    check("s3_e0_valid", rsp_valid2, 0);
    tick();
    check("s3_alu_mode", alu_mode2, 3'b100);
    check("s3_alu_val1", alu_val1_2, 7);
    check("s3_alu_val2", alu_val2_2, 9);
    res2 = 8'h55;
    tick();
    res2 = 8'h66;
    check("s3_e2_valid", rsp_valid2, 0);
    tick();
    check("s3_e3_valid", rsp_valid2, 0);
    res2 = 8'd9;
    tick();
    check("s3_valid", rsp_valid2, 1);
    check("s3_res", rsp_res2, 9);
    check("s3_tag", rsp_tag2, 2);
    check("s3_dz", rsp_dz2, 0);
    res2 = 8'h77;
    @(negedge clk);
    check("s3_res_held", rsp_res2, 9);
    tick();
    check("s3_done", rsp_valid2, 0);
    wait_drain();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
